// File: rtl/horizontal_tf_writeback_if.sv
// Bank write-command bus from the horizontal twiddle writeback stage to the
// eight twiddle ROM/SRAM banks.
//   wr0_en/wr0_addr/wr0_data : lane 0 bank, one P_WIDTH word per write
//   wr_en[k-1]               : lane k (1..7) bank write enable
//   wr_addr/wr_data          : lanes 1..7 packed, lane k at slice k-1
// master = writeback stage (drives commands), slave = bank side (consumes).
interface horizontal_tf_writeback_if #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int AW       = 10
);
  logic                  wr0_en;
  logic [AW-1:0]         wr0_addr;
  logic [P_WIDTH-1:0]    wr0_data;
  logic [6:0]            wr_en;
  logic [7*AW-1:0]       wr_addr;
  logic [7*SD_WIDTH-1:0] wr_data;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr_en, wr_addr, wr_data
  );

  modport slave (
    input wr0_en, wr0_addr, wr0_data, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/horizontal_tf_writeback.sv
// Horizontal twiddle writeback: takes the eight processed lanes from the
// horizontal twiddle generator, pairs the low/high halves of lanes 1..7 into
// 128-bit bank words, assigns sequential per-lane addresses and issues
// registered write commands to the eight twiddle banks.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   start          begin/restart a pass (one-cycle pulse)
//   rom0_data_in   lane 0 word, rom0_w_in its strobe
//   lane_data_in   lanes 1..7 half-words, lane k at slice k-1
//   lane_w_in      lanes 1..7 strobes, 2'b01 low half, 2'b10 high half
//   wr             bank write-command bus (master side)
//   busy           pass in progress
//   done           one-cycle pulse when every lane has written DEPTH words
//   err            sticky protocol error, cleared by rst or start
module horizontal_tf_writeback #(
  parameter int P_WIDTH  = 64,
  parameter int SD_WIDTH = 128,
  parameter int AW       = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [P_WIDTH-1:0]       rom0_data_in,
  input  logic                     rom0_w_in,
  input  logic [7*P_WIDTH-1:0]     lane_data_in,
  input  logic [13:0]              lane_w_in,
  horizontal_tf_writeback_if.master wr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int NL = 7;
  // One extra bit so a counter can hold DEPTH itself (saturated) even when
  // DEPTH == 2**AW.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;
  typedef enum logic {LN_EMPTY, LN_HALF} lane_st_t;

  state_t             state, state_nxt;
  logic               done_nxt;
  logic [CW-1:0]      cnt0;
  logic [CW-1:0]      cnt      [NL];
  lane_st_t           lane_st  [NL];
  lane_st_t           lane_nxt [NL];
  logic [P_WIDTH-1:0] hold     [NL];
  logic               lane0_fire, lane0_bad;
  logic [NL-1:0]      lane_fire, lane_cap, lane_bad;
  logic               take, complete;

  // Strobes only count in ACTIVE, and a start pulse wipes the pass so any
  // strobe arriving with it is dropped.
  assign take = (state == ST_ACTIVE) && !start;
  assign busy = (state == ST_ACTIVE);

  always_comb begin
    complete = (cnt0 == FULL);
    for (int i = 0; i < NL; i++) begin
      if (cnt[i] != FULL || lane_st[i] == LN_HALF) complete = 1'b0;
    end
  end

  // Pass-level FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!start && complete) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-lane decode: lane 0 writes every strobe; lanes 1..7 pair halves.
  always_comb begin
    lane0_fire = 1'b0;
    lane0_bad  = 1'b0;
    lane_fire  = '0;
    lane_cap   = '0;
    lane_bad   = '0;
    for (int i = 0; i < NL; i++) lane_nxt[i] = lane_st[i];

    if (take && rom0_w_in) begin
      if (cnt0 == FULL) lane0_bad  = 1'b1;
      else              lane0_fire = 1'b1;
    end

    for (int i = 0; i < NL; i++) begin
      if (take && lane_w_in[2*i +: 2] != 2'b00) begin
        if (lane_w_in[2*i +: 2] == 2'b11 || cnt[i] == FULL) begin
          lane_bad[i] = 1'b1;
        end else if (lane_w_in[2*i +: 2] == 2'b01) begin
          // A second low half replaces the first but is still an error.
          lane_cap[i] = 1'b1;
          lane_nxt[i] = LN_HALF;
          if (lane_st[i] == LN_HALF) lane_bad[i] = 1'b1;
        end else if (lane_st[i] == LN_HALF) begin
          lane_fire[i] = 1'b1;
          lane_nxt[i]  = LN_EMPTY;
        end else begin
          lane_bad[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr.wr0_en   <= 1'b0;
      wr.wr0_addr <= '0;
      wr.wr0_data <= '0;
      wr.wr_en    <= '0;
      wr.wr_addr  <= '0;
      wr.wr_data  <= '0;
      err         <= 1'b0;
      cnt0        <= '0;
      // NOTE: the hold registers are few and small, so they are reset along
      // with everything else rather than left uninitialised like RAM.
      for (int i = 0; i < NL; i++) begin
        cnt[i]     <= '0;
        lane_st[i] <= LN_EMPTY;
        hold[i]    <= '0;
      end
    end else begin
      wr.wr0_en <= lane0_fire;
      wr.wr_en  <= lane_fire;
      if (lane0_fire) begin
        wr.wr0_addr <= cnt0[AW-1:0];
        wr.wr0_data <= rom0_data_in;
      end
      for (int i = 0; i < NL; i++) begin
        if (lane_fire[i]) begin
          wr.wr_addr[i*AW +: AW] <= cnt[i][AW-1:0];
          wr.wr_data[i*SD_WIDTH +: SD_WIDTH] <= {lane_data_in[i*P_WIDTH +: P_WIDTH], hold[i]};
        end
        if (lane_cap[i]) hold[i] <= lane_data_in[i*P_WIDTH +: P_WIDTH];
      end

      if (start) begin
        cnt0 <= '0;
        err  <= 1'b0;
        for (int i = 0; i < NL; i++) begin
          cnt[i]     <= '0;
          lane_st[i] <= LN_EMPTY;
        end
      end else begin
        if (lane0_fire) cnt0 <= cnt0 + 1'b1;
        for (int i = 0; i < NL; i++) begin
          lane_st[i] <= lane_nxt[i];
          if (lane_fire[i]) cnt[i] <= cnt[i] + 1'b1;
        end
        if (lane0_bad || (|lane_bad)) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_horizontal_tf_writeback.sv
// Self-checking bench for horizontal_tf_writeback with DEPTH = 4.
// A pass-level model predicts every bank write, busy, done and err; a
// negedge process compares the DUT against it every cycle, and the directed
// sequence adds hand-computed literal checks at key points.
module tb_horizontal_tf_writeback;
  localparam int P_WIDTH  = 64;
  localparam int SD_WIDTH = 128;
  localparam int AW       = 10;
  localparam int DEPTH    = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [P_WIDTH-1:0]   rom0_data_in = '0;
  logic                 rom0_w_in = 1'b0;
  logic [7*P_WIDTH-1:0] lane_data_in = '0;
  logic [13:0]          lane_w_in = '0;
  logic                 busy, done, err;

  horizontal_tf_writeback_if #(.P_WIDTH(P_WIDTH), .SD_WIDTH(SD_WIDTH), .AW(AW)) wr_if ();

  horizontal_tf_writeback #(
    .P_WIDTH(P_WIDTH), .SD_WIDTH(SD_WIDTH), .AW(AW), .DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rom0_data_in(rom0_data_in), .rom0_w_in(rom0_w_in),
    .lane_data_in(lane_data_in), .lane_w_in(lane_w_in),
    .wr(wr_if.master),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 is lane 0, indices 1..7 are lanes 1..7.
  int           m_cnt  [8];
  bit           m_half [8];
  logic [63:0]  m_hold [8];
  bit           m_active = 1'b0;
  bit           m_err    = 1'b0;
  bit           e_wr0_en = 1'b0;
  logic [6:0]   e_wr_en  = '0;
  bit           e_done   = 1'b0;
  bit           e_zero   = 1'b0;
  logic [127:0] e_addr [8];
  logic [127:0] e_data [8];

  always @(posedge clk) begin : model
    bit          all_full;
    logic [1:0]  w;
    logic [63:0] d;
    e_wr0_en = 1'b0;
    e_wr_en  = '0;
    e_done   = 1'b0;
    e_zero   = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      e_zero   = 1'b1;
      for (int k = 0; k < 8; k++) begin
        m_cnt[k] = 0; m_half[k] = 1'b0; e_addr[k] = '0; e_data[k] = '0;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_err    = 1'b0;
      for (int k = 0; k < 8; k++) begin
        m_cnt[k] = 0; m_half[k] = 1'b0;
      end
    end else if (m_active) begin
      // Completion is judged on the counts written so far, before this
      // cycle's strobes; done then shows one cycle later.
      all_full = 1'b1;
      for (int k = 0; k < 8; k++) if (m_cnt[k] != DEPTH || m_half[k]) all_full = 1'b0;
      if (rom0_w_in) begin
        if (m_cnt[0] == DEPTH) m_err = 1'b1;
        else begin
          e_wr0_en  = 1'b1;
          e_addr[0] = 128'(m_cnt[0]);
          e_data[0] = 128'(rom0_data_in);
          m_cnt[0]++;
        end
      end
      for (int k = 1; k < 8; k++) begin
        w = lane_w_in[2*k-2 +: 2];
        d = lane_data_in[(k-1)*64 +: 64];
        if (w == 2'b11 || (w != 2'b00 && m_cnt[k] == DEPTH)) m_err = 1'b1;
        else if (w == 2'b01) begin
          if (m_half[k]) m_err = 1'b1;
          m_half[k] = 1'b1;
          m_hold[k] = d;
        end else if (w == 2'b10) begin
          if (!m_half[k]) m_err = 1'b1;
          else begin
            e_wr_en[k-1] = 1'b1;
            e_addr[k]    = 128'(m_cnt[k]);
            e_data[k]    = {d, m_hold[k]};
            m_cnt[k]++;
            m_half[k] = 1'b0;
          end
        end
      end
      if (all_full) begin
        m_active = 1'b0;
        e_done   = 1'b1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("cmp_wr0_en", 128'(wr_if.wr0_en), 128'(e_wr0_en));
    check("cmp_wr_en",  128'(wr_if.wr_en),  128'(e_wr_en));
    check("cmp_busy",   128'(busy),         128'(m_active));
    check("cmp_done",   128'(done),         128'(e_done));
    check("cmp_err",    128'(err),          128'(m_err));
    if (e_wr0_en || e_zero) begin
      check("cmp_wr0_addr", 128'(wr_if.wr0_addr), e_addr[0]);
      check("cmp_wr0_data", 128'(wr_if.wr0_data), e_data[0]);
    end
    for (int k = 1; k < 8; k++) begin
      if (e_wr_en[k-1] || e_zero) begin
        check($sformatf("cmp_wr_addr%0d", k), 128'(wr_if.wr_addr[(k-1)*AW +: AW]), e_addr[k]);
        check($sformatf("cmp_wr_data%0d", k), wr_if.wr_data[(k-1)*SD_WIDTH +: SD_WIDTH], e_data[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [1:0] w, input logic [63:0] d);
    lane_w_in[2*k-2 +: 2]      = w;
    lane_data_in[(k-1)*64 +: 64] = d;
  endtask

  task automatic quiet();
    start     = 1'b0;
    rom0_w_in = 1'b0;
    lane_w_in = '0;
  endtask

  task automatic pulse_start();
    quiet();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    // Reset for two cycles, then strobes with no start.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rom0_w_in    = 1'b1;
      rom0_data_in = 64'h99;
      lane_w_in    = (i % 2 == 1) ? {7{2'b10}} : {7{2'b01}};
      step();
      check("idle_wr0_en", 128'(wr_if.wr0_en), 128'(0));
      check("idle_wr_en",  128'(wr_if.wr_en),  128'(0));
      check("idle_err",    128'(err),          128'(0));
      check("idle_busy",   128'(busy),         128'(0));
    end

    // Lane 0 stream.
    pulse_start();
    check("start_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) begin
      rom0_w_in    = 1'b1;
      rom0_data_in = 64'(8'h11 + i);
      step();
      check("l0_en",   128'(wr_if.wr0_en),   128'(1));
      check("l0_addr", 128'(wr_if.wr0_addr), 128'(i));
      check("l0_data", 128'(wr_if.wr0_data), 128'(8'h11 + i));
    end
    quiet();
    step();
    check("l0_stop", 128'(wr_if.wr0_en), 128'(0));

    // Lane 3 pairing with idle gap.
    set_lane(3, 2'b01, 64'hAAAA);
    step();
    check("l3_low_no_wr", 128'(wr_if.wr_en), 128'(0));
    set_lane(3, 2'b00, 64'h0);
    step();
    step();
    set_lane(3, 2'b10, 64'hBBBB);
    step();
    check("l3_en",   128'(wr_if.wr_en), 128'(7'b0000100));
    check("l3_addr", 128'(wr_if.wr_addr[2*AW +: AW]), 128'(0));
    check("l3_data", wr_if.wr_data[2*SD_WIDTH +: SD_WIDTH],
          {64'h0000_0000_0000_BBBB, 64'h0000_0000_0000_AAAA});
    check("l3_err",  128'(err), 128'(0));
    quiet();
    step();

    // Protocol errors on lane 5.
    set_lane(5, 2'b10, 64'h5555);
    step();
    check("l5_orphan_err", 128'(err),         128'(1));
    check("l5_orphan_wr",  128'(wr_if.wr_en), 128'(0));
    pulse_start();
    check("restart_err", 128'(err), 128'(0));
    set_lane(5, 2'b01, 64'h5100);
    step();
    check("l5_first_low_err", 128'(err), 128'(0));
    set_lane(5, 2'b01, 64'h5200);
    step();
    check("l5_dbl_low_err", 128'(err),         128'(1));
    check("l5_dbl_low_wr",  128'(wr_if.wr_en), 128'(0));
    set_lane(5, 2'b10, 64'h5300);
    step();
    check("l5_en",   128'(wr_if.wr_en), 128'(7'b0010000));
    check("l5_addr", 128'(wr_if.wr_addr[4*AW +: AW]), 128'(0));
    check("l5_data", wr_if.wr_data[4*SD_WIDTH +: SD_WIDTH],
          {64'h0000_0000_0000_5300, 64'h0000_0000_0000_5200});
    quiet();
    step();

    // Full pass on all eight lanes.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      rom0_w_in    = 1'b1;
      rom0_data_in = 64'(16'h0100 + i);
      for (int k = 1; k < 8; k++) set_lane(k, 2'b01, 64'(16'hA000 + k*16 + i));
      step();
      rom0_w_in = 1'b0;
      for (int k = 1; k < 8; k++) set_lane(k, 2'b10, 64'(16'hB000 + k*16 + i));
      step();
      check("full_wr_en",  128'(wr_if.wr_en), 128'(7'h7f));
      check("full_addr7",  128'(wr_if.wr_addr[6*AW +: AW]), 128'(i));
      check("full_data7",  wr_if.wr_data[6*SD_WIDTH +: SD_WIDTH],
            {64'(16'hB070 + i), 64'(16'hA070 + i)});
      check("full_no_done", 128'(done), 128'(0));
    end
    quiet();
    step();
    check("pass_done",     128'(done),          128'(1));
    check("pass_busy_low", 128'(busy),          128'(0));
    check("pass_no_wr",    128'(wr_if.wr_en),   128'(0));
    check("pass_err",      128'(err),           128'(0));
    step();
    check("done_one_cycle", 128'(done), 128'(0));
    // Strobes after completion.
    rom0_w_in    = 1'b1;
    rom0_data_in = 64'hEE;
    lane_w_in    = {7{2'b01}};
    step();
    check("post_wr0", 128'(wr_if.wr0_en), 128'(0));
    rom0_w_in = 1'b0;
    lane_w_in = {7{2'b10}};
    step();
    check("post_wr",  128'(wr_if.wr_en), 128'(0));
    check("post_err", 128'(err),         128'(0));
    quiet();
    step();

    // Reset in the middle of a pass.
    pulse_start();
    rom0_w_in    = 1'b1;
    rom0_data_in = 64'h21;
    step();
    rom0_data_in = 64'h22;
    step();
    check("mid_addr1", 128'(wr_if.wr0_addr), 128'(1));
    quiet();
    rst = 1'b1;
    step();
    check("rst_wr0_en",   128'(wr_if.wr0_en),   128'(0));
    check("rst_wr0_addr", 128'(wr_if.wr0_addr), 128'(0));
    check("rst_wr0_data", 128'(wr_if.wr0_data), 128'(0));
    check("rst_busy",     128'(busy),           128'(0));
    rst = 1'b0;
    step();
    pulse_start();
    rom0_w_in    = 1'b1;
    rom0_data_in = 64'h31;
    step();
    check("rerun_en",   128'(wr_if.wr0_en),   128'(1));
    check("rerun_addr", 128'(wr_if.wr0_addr), 128'(0));
    check("rerun_data", 128'(wr_if.wr0_data), 128'(8'h31));
    quiet();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
